// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the parametrised restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  localparam int DIV_N_DEFAULT = 6;

  // Iteration counter must be able to hold N.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial subtract, restore on borrow.
module div_step
  import divider_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic [N:0]   r,
  input  logic [N-1:0] qs,
  input  logic [N-1:0] divisor_mag,
  output logic [N:0]   r_next,
  output logic [N-1:0] qs_next
);

  logic [N:0] r_shift;
  logic [N:0] diff;

  always_comb begin
    r_shift = {r[N-1:0], qs[N-1]};
    diff    = r_shift - {1'b0, divisor_mag};
    // R stays below the divisor, so an unsigned compare is the sign test of the trial difference.
    if (r_shift >= {1'b0, divisor_mag}) begin
      r_next  = diff;
      qs_next = {qs[N-2:0], 1'b1};
    end else begin
      r_next  = r_shift;
      qs_next = {qs[N-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/param_restoring_divider.sv
// Multi-cycle 2N/N restoring divider with signed mode, error detection and busy/done handshake.
module param_restoring_divider
  import divider_pkg::*;
#(
  parameter int N = DIV_N_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           busy,
  output logic           done,
  output logic           div_by_zero,
  output logic           overflow
);

  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  state_t         state_reg, state_next;
  logic [CW-1:0]  iter_reg;
  logic [N:0]     r_reg;
  logic [N-1:0]   qs_reg;
  logic [N-1:0]   dvs_mag_reg;
  logic           neg_q_reg;
  logic           neg_r_reg;

  logic [2*N-1:0] dvd_mag;
  logic [N-1:0]   dvs_mag;
  logic           is_zero;
  logic           is_ovf;
  logic [N:0]     r_step;
  logic [N-1:0]   qs_step;

  always_comb begin
    dvd_mag = (signed_mode && dividend[2*N-1]) ? -dividend : dividend;
    dvs_mag = (signed_mode && divisor[N-1]) ? -divisor : divisor;
    is_zero = (divisor == '0);
    // Signed test is conservative: a quotient of exactly -2^(N-1) is reported as overflow.
    if (signed_mode)
      is_ovf = (dvd_mag[2*N-1:N-1] >= {1'b0, dvs_mag});
    else
      is_ovf = (dvd_mag[2*N-1:N] >= dvs_mag);
  end

  div_step #(.N(N)) u_step (
    .r           (r_reg),
    .qs          (qs_reg),
    .divisor_mag (dvs_mag_reg),
    .r_next      (r_step),
    .qs_next     (qs_step)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (is_zero || is_ovf) ? DONE : RUN;
      RUN:     if (iter_reg == LAST_ITER) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iter_reg    <= '0;
      r_reg       <= '0;
      qs_reg      <= '0;
      dvs_mag_reg <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          r_reg       <= {1'b0, dvd_mag[2*N-1:N]};
          qs_reg      <= dvd_mag[N-1:0];
          dvs_mag_reg <= dvs_mag;
          neg_q_reg   <= signed_mode && (dividend[2*N-1] ^ divisor[N-1]);
          neg_r_reg   <= signed_mode && dividend[2*N-1];
          iter_reg    <= '0;
          quotient    <= is_zero ? '1 : '0;
          remainder   <= '0;
          div_by_zero <= is_zero;
          overflow    <= !is_zero && is_ovf;
        end
        RUN: begin
          r_reg    <= r_step;
          qs_reg   <= qs_step;
          iter_reg <= iter_reg + 1'b1;
        end
        FIX: begin
          quotient  <= neg_q_reg ? -qs_reg : qs_reg;
          remainder <= neg_r_reg ? -r_reg[N-1:0] : r_reg[N-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/param_restoring_divider.md
Name: param_restoring_divider

Overview:
- Parametrised successor to the team's fixed 12/6-bit restoring divider.
- Divides a 2N-bit dividend by an N-bit divisor, producing an N-bit quotient and an N-bit remainder, one quotient bit per cycle.
- Adds a per-operation signed/unsigned mode, divide-by-zero and quotient-overflow detection, and a busy/done handshake.
- Sits in the CA arithmetic datapath as a multi-cycle functional unit driven by a controller.

Parameters:
- N, default 6: divisor, quotient and remainder width; the dividend is 2N bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands; latched with start.
- dividend  in  2N  latched with start.
- divisor  in  N  latched with start.
- quotient  out  N  result, held until the next accepted start.
- remainder  out  N  result, held until the next accepted start.
- busy  out  1  high from the cycle after the accepted start through the done cycle.
- done  out  1  one-cycle pulse when the results are valid.
- div_by_zero  out  1  error flag, held with the results.
- overflow  out  1  error flag, held with the results.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - If start=1 at edge t: latch the operands and mode, and compute |dividend| and |divisor|. Magnitudes are taken only in signed mode; magnitude widths are 2N and N unsigned.
  - Clear quotient, remainder and the flags at edge t.
  - If divisor==0: set div_by_zero, set quotient to all-ones and remainder to 0, go to DONE.
  - Else if overflow: set overflow, set quotient and remainder to 0, go to DONE.
    - Unsigned overflow test: |dividend|[2N-1:N] >= |divisor|.
    - Signed overflow test: |dividend|[2N-1:N-1] >= |divisor|. This is conservative: a quotient of exactly -2^(N-1) is flagged as overflow.
  - Otherwise go to RUN.
  - div_by_zero has priority over overflow.
- RUN, exactly N cycles, counted by an iteration counter of ceil(log2(N+1)) bits:
  - Registers: partial remainder R (N+1 bits), initialised to {0, |dividend|[2N-1:N]}; quotient shift register Qs, initialised to |dividend|[N-1:0].
  - Each cycle: R' = {R[N-1:0], Qs[N-1]}; T = R' - {0, |divisor|}.
  - If T >= 0: R = T and shift 1 into Qs. Otherwise R = R' (restore) and shift 0 into Qs.
- FIX, 1 cycle:
  - In signed mode, negate the quotient if the operand signs differ.
  - Give the remainder the sign of the dividend (truncation toward zero).
  - Drive quotient=Qs and remainder=R[N-1:0], with the correction applied.
- DONE, 1 cycle:
  - done=1; goes to IDLE unconditionally.
  - start asserted during DONE is ignored; it must be re-asserted in IDLE.
- Latency, with start accepted at edge t:
  - Normal operation: done is high in the cycle after edge t+N+1, i.e. N+2 cycles total.
  - Error operation: done is high in the cycle after edge t, i.e. 1 cycle.
- busy=1 in RUN, FIX and DONE. start while busy is ignored, and the latched operands do not change.
- Operand inputs may change freely after the capture edge.

Decomposition:
- Package divider_pkg holds:
  - the state enum typedef (IDLE/RUN/FIX/DONE);
  - the localparam default N=6;
  - a function computing the counter width.
- One natural sub-module: div_step. It is the combinational single restoring iteration: inputs R, Qs, |divisor|; outputs next R, next Qs. It is instantiated once in the RUN datapath.

Test Plan:
- Unsigned basic: N=6, dividend=12'b001101011000 (856), divisor=6'b011101 (29) -> quotient=29, remainder=15, done exactly 8 cycles after start. Repeat with 856/12 -> 71 exceeds 6 bits -> overflow=1, done 1 cycle after start.
- Signed: signed_mode=1, dividend=12'hCA8 (-856), divisor=29 -> quotient=6'b100011 (-29), remainder=6'b110001 (-15). Also 856 / -29 -> quotient=-29, remainder=+15.
- Divide by zero: divisor=0, dividend=856 -> div_by_zero=1, overflow=0, quotient=6'h3F, remainder=0, done 1 cycle after start.
- Overflow: unsigned dividend=12'hFFF, divisor=1 -> overflow=1. Signed dividend=12'd1024, divisor=1 -> overflow=1.
- Handshake:
  - A start pulse mid-RUN with new operands is ignored, and the original result is produced.
  - A start held during DONE is not accepted; start re-asserted in IDLE begins a new operation.
  - Results hold steady between operations.
- Reset: rst=0 asserted in the third RUN cycle -> all outputs drop to 0 immediately (asynchronously), with no done. A fresh start after release gives the correct result. Also rerun the basic case with N=8: 16'd50000 / 8'd200 -> quotient=250, remainder=0.
